alu_issue_stage: RTL and testbench

Upstream issue stage for the combinational ALU (operand width W, ops add/sub/and/or/xor). Accepts operation commands on a valid/ready channel and buffers them in a small FIFO. Presents the FIFO head to the ALU, then registers the ALU result and flags into an output register with its own valid/ready channel. It is the only sequential wrapper between command producers and the ALU datapath.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/alu_issue_stage.sv | 129 ++++++++++++
 tb/tb_alu_issue_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, command payload and the op legality check.
package alu_pkg;

   localparam int unsigned OP_W  = 3;
   localparam int unsigned ALU_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100
   } op_e;

   // Default-width command payload; wrappers with another width declare their own.
   typedef struct packed {
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
      logic [OP_W-1:0]  op;
   } alu_cmd_t;

   // Codes 101..111 are undefined for the ALU.
   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return op <= OP_W'(OP_XOR);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count.
// Ports: clk/rst (async active-high), push_i/pop_i strobes, wdata_i,
//        rdata_o (head entry), full_o, empty_o, count_o (occupancy).
// Push while full and pop while empty are ignored.
module sync_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [DATA_W-1:0]            wdata_i,
   output logic [DATA_W-1:0]            rdata_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointer/count next state; DEPTH is a power of 2 so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once count says they are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU.
// Ports: clk/rst (async active-high); in_* command valid/ready channel;
//        alu_a/alu_b/alu_op drive the ALU from the FIFO head (zero when empty);
//        alu_y/alu_zero/alu_carry return the ALU response; out_* registered
//        result valid/ready channel with op and illegal-op flag; count = FIFO fill.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned W     = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [W-1:0]                 in_a,
   input  logic [W-1:0]                 in_b,
   input  logic [2:0]                   in_op,
   output logic [W-1:0]                 alu_a,
   output logic [W-1:0]                 alu_b,
   output logic [2:0]                   alu_op,
   input  logic [W-1:0]                 alu_y,
   input  logic                         alu_zero,
   input  logic                         alu_carry,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [W-1:0]                 out_y,
   output logic                         out_zero,
   output logic                         out_carry,
   output logic [2:0]                   out_op,
   output logic                         out_err,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   typedef struct packed {
      logic [W-1:0]    a;
      logic [W-1:0]    b;
      logic [OP_W-1:0] op;
   } cmd_t;

   localparam int unsigned CMD_W = $bits(cmd_t);

   cmd_t       wr_cmd, head_cmd;
   logic       fifo_full, fifo_empty;
   logic       push, pop, head_legal;

   logic       ready_en_q;
   logic       out_valid_q, out_valid_d;
   logic [W-1:0] out_y_q, out_y_d;
   logic       out_zero_q, out_zero_d;
   logic       out_carry_q, out_carry_d;
   logic [2:0] out_op_q, out_op_d;
   logic       out_err_q, out_err_d;

   assign wr_cmd = {in_a, in_b, in_op};

   sync_fifo #(
      .DATA_W (CMD_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_cmd),
      .rdata_o (head_cmd),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (count)
   );

   // ready_en_q keeps in_ready low through reset and the first edge after it.
   assign in_ready   = ready_en_q && !fifo_full;
   assign push       = in_valid && in_ready;
   assign pop        = !fifo_empty && (!out_valid_q || out_ready);
   assign head_legal = is_legal_op(head_cmd.op);

   assign alu_a  = fifo_empty ? '0 : head_cmd.a;
   assign alu_b  = fifo_empty ? '0 : head_cmd.b;
   assign alu_op = fifo_empty ? '0 : head_cmd.op;

   // Output register: capture on pop, clear valid when drained without refill.
   always_comb begin
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_zero_d  = out_zero_q;
      out_carry_d = out_carry_q;
      out_op_d    = out_op_q;
      out_err_d   = out_err_q;
      if (pop) begin
         out_valid_d = 1'b1;
         out_op_d    = head_cmd.op;
         out_err_d   = !head_legal;
         out_y_d     = head_legal ? alu_y     : '0;
         out_zero_d  = head_legal ? alu_zero  : 1'b0;
         out_carry_d = head_legal ? alu_carry : 1'b0;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_en_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_zero_q  <= 1'b0;
         out_carry_q <= 1'b0;
         out_op_q    <= '0;
         out_err_q   <= 1'b0;
      end else begin
         ready_en_q  <= 1'b1;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_zero_q  <= out_zero_d;
         out_carry_q <= out_carry_d;
         out_op_q    <= out_op_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_zero  = out_zero_q;
   assign out_carry = out_carry_q;
   assign out_op    = out_op_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, queue-based reference model,
// directed scenarios followed by random traffic.
module tb_alu_issue_stage;
   import alu_pkg::*;

   localparam int unsigned W     = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid, in_ready;
   logic [W-1:0]  in_a, in_b;
   logic [2:0]    in_op;
   logic [W-1:0]  alu_a, alu_b, alu_y;
   logic [2:0]    alu_op;
   logic          alu_zero, alu_carry;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_y;
   logic          out_zero, out_carry, out_err;
   logic [2:0]    out_op;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   alu_issue_stage #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_y(alu_y), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_zero(out_zero), .out_carry(out_carry),
      .out_op(out_op), .out_err(out_err), .count(count)
   );

   typedef struct packed {
      logic [W-1:0] y;
      logic         z;
      logic         c;
      logic         err;
   } res_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   op;
   } cmd_t;

   // Expected result of one command, straight from the op definitions.
   function automatic res_t ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] op);
      res_t r;
      int unsigned s;
      r = '0;
      case (op)
         3'd0: begin s = 32'(a) + 32'(b); r.y = W'(s); r.c = s[W]; end
         3'd1: begin r.y = W'(a - b); r.c = (a < b); end
         3'd2: r.y = a & b;
         3'd3: r.y = a | b;
         3'd4: r.y = a ^ b;
         default: r.err = 1'b1;
      endcase
      if (!r.err) r.z = (r.y == '0);
      return r;
   endfunction

   // Behavioural ALU; illegal ops return junk that the stage must ignore.
   res_t alu_r;
   assign alu_r     = ref_result(alu_a, alu_b, alu_op);
   assign alu_y     = alu_r.err ? 4'hA : alu_r.y;
   assign alu_zero  = alu_r.err ? 1'b1 : alu_r.z;
   assign alu_carry = alu_r.err ? 1'b1 : alu_r.c;

   // Reference model state
   cmd_t       q_m[$];
   logic       ov_m;
   res_t       ores_m;
   logic [2:0] oop_m;
   logic       ren_m;

   int n_assert = 0;
   int n_fail   = 0;
   bit acc;

   task automatic reset_model();
      q_m.delete();
      ov_m   = 1'b0;
      ores_m = '0;
      oop_m  = '0;
      ren_m  = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      cmd_t h;
      h = (q_m.size() != 0) ? q_m[0] : '0;
      chk("in_ready",  32'(in_ready),  32'(ren_m && q_m.size() != DEPTH));
      chk("count",     32'(count),     32'(q_m.size()));
      chk("alu_a",     32'(alu_a),     32'(h.a));
      chk("alu_b",     32'(alu_b),     32'(h.b));
      chk("alu_op",    32'(alu_op),    32'(h.op));
      chk("out_valid", 32'(out_valid), 32'(ov_m));
      chk("out_y",     32'(out_y),     32'(ores_m.y));
      chk("out_zero",  32'(out_zero),  32'(ores_m.z));
      chk("out_carry", 32'(out_carry), 32'(ores_m.c));
      chk("out_err",   32'(out_err),   32'(ores_m.err));
      chk("out_op",    32'(out_op),    32'(oop_m));
   endtask

   // One clock: check at negedge, advance model at posedge, return at next negedge.
   task automatic step(output bit accepted);
      bit   push_m, pop_m;
      cmd_t c, h;
      check_all();
      push_m = !rst && in_valid && ren_m && (q_m.size() != DEPTH);
      pop_m  = !rst && (q_m.size() != 0) && (!ov_m || out_ready);
      c = {in_a, in_b, in_op};
      @(posedge clk);
      if (rst) begin
         reset_model();
      end else begin
         if (pop_m) begin
            h      = q_m.pop_front();
            ores_m = ref_result(h.a, h.b, h.op);
            oop_m  = h.op;
            ov_m   = 1'b1;
         end else if (ov_m && out_ready) begin
            ov_m = 1'b0;
         end
         if (push_m) q_m.push_back(c);
         ren_m = 1'b1;
      end
      accepted = push_m;
      @(negedge clk);
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
   endtask

   initial begin
      in_valid  = 1'b1;
      in_a      = 4'h3;
      in_b      = 4'h4;
      in_op     = 3'd0;
      out_ready = 1'b1;
      reset_model();
      @(negedge clk);

      // Reset held with a pending command: nothing accepted
      repeat (3) step(acc);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_count",    32'(count),    32'd0);
      in_valid = 1'b0;
      rst = 1'b0;
      step(acc);
      chk("release_in_ready", 32'(in_ready), 32'd1);

      // Single ADD: 9 + 8 = 1 carry 1, valid exactly one cycle two edges later
      drive(4'h9, 4'h8, 3'd0);
      step(acc);
      in_valid = 1'b0;
      chk("add_not_yet", 32'(out_valid), 32'd0);
      step(acc);
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_y",     32'(out_y),     32'h1);
      chk("add_carry", 32'(out_carry), 32'd1);
      chk("add_zero",  32'(out_zero),  32'd0);
      step(acc);
      chk("add_one_cycle", 32'(out_valid), 32'd0);

      // SUB flags: 3-3 zero, 2-3 borrow
      drive(4'h3, 4'h3, 3'd1);
      step(acc);
      drive(4'h2, 4'h3, 3'd1);
      step(acc);
      chk("sub0_y",    32'(out_y),     32'h0);
      chk("sub0_zero", 32'(out_zero),  32'd1);
      chk("sub0_c",    32'(out_carry), 32'd0);
      in_valid = 1'b0;
      step(acc);
      chk("sub1_y", 32'(out_y),     32'hF);
      chk("sub1_c", 32'(out_carry), 32'd1);
      step(acc);

      // Backpressure until full, then drain in order
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive(W'(k + 1), W'(k + 2), 3'(k % 5));
         step(acc);
      end
      drive(4'hE, 4'h1, 3'd4);
      repeat (2) step(acc);
      chk("full_count",    32'(count),     32'(DEPTH));
      chk("full_in_ready", 32'(in_ready),  32'd0);
      chk("full_hold",     32'(out_valid), 32'd1);
      chk("full_head_out", 32'(out_y),     32'h3);
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step(acc);
         if (acc) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      repeat (2) step(acc);
      chk("drained_ready", 32'(in_ready), 32'd1);

      // Illegal op between two ANDs
      drive(4'hC, 4'hA, 3'd2);
      step(acc);
      drive(4'h5, 4'h1, 3'd6);
      step(acc);
      chk("and1_y", 32'(out_y), 32'h8);
      drive(4'hF, 4'h3, 3'd2);
      step(acc);
      chk("ill_err",   32'(out_err),   32'd1);
      chk("ill_y",     32'(out_y),     32'h0);
      chk("ill_op",    32'(out_op),    32'h6);
      chk("ill_carry", 32'(out_carry), 32'd0);
      in_valid = 1'b0;
      step(acc);
      chk("and2_y",   32'(out_y),   32'h3);
      chk("and2_err", 32'(out_err), 32'd0);
      step(acc);

      // Reset mid-stream with queued work and a held result
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(W'(k), 4'h1, 3'd0);
         step(acc);
      end
      in_valid = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_count", 32'(count),     32'd0);
      reset_model();
      @(negedge clk);
      step(acc);
      rst = 1'b0;
      out_ready = 1'b1;
      step(acc);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      drive(4'h1, 4'h2, 3'd0);
      step(acc);
      in_valid = 1'b0;
      step(acc);
      chk("post_rst_add_v", 32'(out_valid), 32'd1);
      chk("post_rst_add_y", 32'(out_y),     32'h3);
      step(acc);

      // Random traffic including illegal ops and random backpressure
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_a      = W'($urandom);
         in_b      = W'($urandom);
         in_op     = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 9) < 6);
         step(acc);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (8) step(acc);
      chk("final_count", 32'(count),     32'd0);
      chk("final_valid", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
